// File: rtl/bp_cfg_hub_if.sv
// Command, core config-bus and response signals of the multi-core config hub.
// The slave modport is the hub's view; master is the host/core-side view.
interface bp_cfg_hub_if #(
  parameter int num_cores_p      = 4,
  parameter int cfg_addr_width_p = 16,
  parameter int cfg_data_width_p = 64,
  parameter int tag_width_p      = 8
);
  localparam int core_sel_width_lp = $clog2(num_cores_p) + 1;

  logic                                          cmd_v_i;
  logic                                          cmd_ready_o;
  logic                                          cmd_w_i;
  logic [core_sel_width_lp+cfg_addr_width_p-1:0] cmd_addr_i;
  logic [cfg_data_width_p-1:0]                   cmd_data_i;
  logic [tag_width_p-1:0]                        cmd_tag_i;

  logic [num_cores_p-1:0]                        cfg_w_v_o;
  logic [num_cores_p-1:0]                        cfg_r_v_o;
  logic [cfg_addr_width_p-1:0]                   cfg_addr_o;
  logic [cfg_data_width_p-1:0]                   cfg_data_o;
  logic [num_cores_p*cfg_data_width_p-1:0]       cfg_rdata_i;
  logic [num_cores_p-1:0]                        freeze_o;

  logic                                          resp_v_o;
  logic                                          resp_ready_i;
  logic [cfg_data_width_p-1:0]                   resp_data_o;
  logic [tag_width_p-1:0]                        resp_tag_o;
  logic                                          resp_err_o;

  modport slave (
    input  cmd_v_i, cmd_w_i, cmd_addr_i, cmd_data_i, cmd_tag_i,
    output cmd_ready_o,
    output cfg_w_v_o, cfg_r_v_o, cfg_addr_o, cfg_data_o, freeze_o,
    input  cfg_rdata_i,
    output resp_v_o, resp_data_o, resp_tag_o, resp_err_o,
    input  resp_ready_i
  );

  modport master (
    output cmd_v_i, cmd_w_i, cmd_addr_i, cmd_data_i, cmd_tag_i,
    input  cmd_ready_o,
    input  cfg_w_v_o, cfg_r_v_o, cfg_addr_o, cfg_data_o, freeze_o,
    output cfg_rdata_i,
    input  resp_v_o, resp_data_o, resp_tag_o, resp_err_o,
    output resp_ready_i
  );
endinterface

// File: rtl/bp_cfg_hub.sv
// Multi-core config hub: decodes host config commands into per-core strobes,
// keeps per-core freeze bits locally and returns in-order responses via a FIFO.
module bp_cfg_hub #(
  parameter int num_cores_p      = 4,
  parameter int cfg_addr_width_p = 16,
  parameter int cfg_data_width_p = 64,
  parameter int tag_width_p      = 8,
  parameter int resp_fifo_els_p  = 4
) (
  input  logic           clk_i,
  input  logic           reset_i,
  bp_cfg_hub_if.slave    hub
);
  localparam int core_sel_width_lp = $clog2(num_cores_p) + 1;
  localparam int ptr_w_lp          = $clog2(resp_fifo_els_p);
  localparam int cnt_w_lp          = $clog2(resp_fifo_els_p + 1);
  localparam int occ_w_lp          = cnt_w_lp + 1;

  function automatic logic [ptr_w_lp-1:0] f_bump(input logic [ptr_w_lp-1:0] p);
    return (p == ptr_w_lp'(resp_fifo_els_p - 1)) ? '0 : p + 1'b1;
  endfunction

  logic [core_sel_width_lp-1:0] w_sel;
  logic [cfg_addr_width_p-1:0]  w_off;
  logic                         w_bcast, w_in_range, w_err, w_local;
  logic                         w_ready, w_accept;
  logic [num_cores_p-1:0]       w_onehot, w_tgt;
  logic [num_cores_p-1:0]       r_freeze;

  assign w_sel      = hub.cmd_addr_i[cfg_addr_width_p +: core_sel_width_lp];
  assign w_off      = hub.cmd_addr_i[cfg_addr_width_p-1:0];
  assign w_bcast    = &w_sel;
  assign w_in_range = (w_sel < core_sel_width_lp'(num_cores_p));
  // Broadcast is legal only for writes; everything else off the core map errors.
  assign w_err      = ~w_in_range & ~(w_bcast & hub.cmd_w_i);
  assign w_local    = (w_off == cfg_addr_width_p'(1));
  assign w_accept   = hub.cmd_v_i & w_ready;

  always_comb begin
    w_onehot = '0;
    for (int i = 0; i < num_cores_p; i++)
      w_onehot[i] = (w_sel == core_sel_width_lp'(i));
  end

  assign w_tgt = w_bcast ? {num_cores_p{1'b1}} : w_onehot;

  always_comb begin
    hub.cfg_w_v_o = '0;
    hub.cfg_r_v_o = '0;
    if (w_accept & ~w_err & ~w_local) begin
      if (hub.cmd_w_i) hub.cfg_w_v_o = w_tgt;
      else             hub.cfg_r_v_o = w_onehot;
    end
  end

  assign hub.cfg_addr_o = w_accept ? w_off : '0;
  assign hub.cfg_data_o = w_accept ? hub.cmd_data_i : '0;
  assign hub.freeze_o   = r_freeze;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)
      r_freeze <= '1;
    else if (w_accept & hub.cmd_w_i & w_local & ~w_err)
      r_freeze <= (r_freeze & ~w_tgt) | (w_tgt & {num_cores_p{hub.cmd_data_i[0]}});
  end

  // ---- stage A -> stage B: accepted command in flight ----
  logic                   r_vld_p1;
  logic [tag_width_p-1:0] r_tag_p1;
  logic                   r_w_p1, r_err_p1, r_local_p1;
  logic [num_cores_p-1:0] r_sel_oh_p1;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) r_vld_p1 <= 1'b0;
    else         r_vld_p1 <= w_accept;
  end

  always_ff @(posedge clk_i) begin
    if (w_accept) begin
      r_tag_p1    <= hub.cmd_tag_i;
      r_w_p1      <= hub.cmd_w_i;
      r_err_p1    <= w_err;
      r_local_p1  <= w_local;
      r_sel_oh_p1 <= w_onehot;
    end
  end

  logic [cfg_data_width_p-1:0] w_core_rdata_p1, w_resp_data_p1;
  logic                        w_frz_bit_p1;

  always_comb begin
    w_core_rdata_p1 = '0;
    for (int i = 0; i < num_cores_p; i++)
      if (r_sel_oh_p1[i])
        w_core_rdata_p1 = w_core_rdata_p1 | hub.cfg_rdata_i[i*cfg_data_width_p +: cfg_data_width_p];
  end

  assign w_frz_bit_p1   = |(r_freeze & r_sel_oh_p1);
  assign w_resp_data_p1 = (r_err_p1 | r_w_p1) ? '0 :
                          r_local_p1          ? cfg_data_width_p'(w_frz_bit_p1) :
                                                w_core_rdata_p1;

  // ---- stage B -> response FIFO ----
  logic [cfg_data_width_p-1:0] r_fifo_data [resp_fifo_els_p];
  logic [tag_width_p-1:0]      r_fifo_tag  [resp_fifo_els_p];
  logic                        r_fifo_err  [resp_fifo_els_p];
  logic [ptr_w_lp-1:0]         r_wr_ptr, r_rd_ptr;
  logic [cnt_w_lp-1:0]         r_count;
  logic                        w_push, w_pop, w_resp_v;
  logic [occ_w_lp-1:0]         w_occ;

  assign w_push   = r_vld_p1;
  assign w_resp_v = (r_count != '0);
  assign w_pop    = w_resp_v & hub.resp_ready_i;
  // Credits cover queued entries plus the one still in stage B, so a push never overflows.
  assign w_occ    = occ_w_lp'(r_count) + occ_w_lp'(r_vld_p1);
  assign w_ready  = ~reset_i & (w_occ < occ_w_lp'(resp_fifo_els_p));

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_fifo_data[r_wr_ptr] <= w_resp_data_p1;
      r_fifo_tag[r_wr_ptr]  <= r_tag_p1;
      r_fifo_err[r_wr_ptr]  <= r_err_p1;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= f_bump(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= f_bump(r_rd_ptr);
      if (w_push & ~w_pop)      r_count <= r_count + 1'b1;
      else if (~w_push & w_pop) r_count <= r_count - 1'b1;
    end
  end

  assign hub.cmd_ready_o = w_ready;
  assign hub.resp_v_o    = w_resp_v;
  assign hub.resp_data_o = r_fifo_data[r_rd_ptr];
  assign hub.resp_tag_o  = r_fifo_tag[r_rd_ptr];
  assign hub.resp_err_o  = r_fifo_err[r_rd_ptr];
endmodule
